// File: rtl/flag_unit.sv
// Flag register, branch-condition evaluator and LIFO flag save stack for the single-cycle CPU.
// Latency: flags/count/err update one clk after we_flags/push/pop; cond_true is combinational.
// Backpressure: none; push when full and pop when empty are dropped and recorded in sticky err bits.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   we_flags              load {carry_in, zero_in, negative_in} into the flag register
//   carry_in/zero_in/negative_in  ALU status flags
//   cond[2:0]             branch condition select (always/z/~z/c/~c/n/~n/never)
//   push, pop             save / restore the flag register on the stack
//   clr_err               clear err_ovf/err_unf
//   flags[2:0]            registered {carry, zero, negative}
//   cond_true             selected condition holds
//   count                 occupied stack entries 0..DEPTH
//   stack_full/stack_empty  derived from registered count only
//   err_ovf/err_unf       sticky overflow / underflow
//
// Build option: define FLAG_BYPASS_EN to forward incoming ALU flags into cond_true
// while we_flags=1 and no valid pop is in progress.

module flag_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_flags,
    input  logic             carry_in,
    input  logic             zero_in,
    input  logic             negative_in,
    input  logic [2:0]       cond,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic [2:0]       flags,
    output logic             cond_true,
    output logic [PTR_W:0]   count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [2:0]       stack_mem [DEPTH];
    logic             push_only;
    logic             pop_only;
    logic             do_push;
    logic             do_pop;
    logic             ovf_evt;
    logic             unf_evt;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;
    logic [2:0]       alu_flags;
    logic [2:0]       eval_flags;

    assign stack_full  = (count == FULL_CNT);
    assign stack_empty = (count == '0);

    // Simultaneous push and pop cancel out: no stack activity and no error.
    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;
    assign do_push   = push_only & ~stack_full;
    assign do_pop    = pop_only & ~stack_empty;
    assign ovf_evt   = push_only & stack_full;
    assign unf_evt   = pop_only & stack_empty;

    // count==DEPTH has zero low bits, so wr_idx-1 still lands on the top entry.
    assign wr_idx  = count[PTR_W-1:0];
    assign top_idx = wr_idx - PTR_W'(1);

    assign alu_flags = {carry_in, zero_in, negative_in};

    // Stack contents need no reset; only count decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[wr_idx] <= flags;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags   <= 3'b000;
            count   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            // A valid pop restores the saved word and beats a same-cycle flag write.
            if (do_pop) begin
                flags <= stack_mem[top_idx];
            end else if (we_flags) begin
                flags <= alu_flags;
            end

            if (do_push) begin
                count <= count + (PTR_W+1)'(1);
            end else if (do_pop) begin
                count <= count - (PTR_W+1)'(1);
            end

            // A fresh error in the clearing cycle keeps the bit set.
            err_ovf <= ovf_evt | (err_ovf & ~clr_err);
            err_unf <= unf_evt | (err_unf & ~clr_err);
        end
    end

`ifdef FLAG_BYPASS_EN
    // Forward the incoming flags so compare-and-branch resolves in one CPU cycle.
    assign eval_flags = (we_flags && !do_pop) ? alu_flags : flags;
`else
    assign eval_flags = flags;
`endif

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = eval_flags[1];
            3'b010:  cond_true = ~eval_flags[1];
            3'b011:  cond_true = eval_flags[2];
            3'b100:  cond_true = ~eval_flags[2];
            3'b101:  cond_true = eval_flags[0];
            3'b110:  cond_true = ~eval_flags[0];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: queue-based reference model compared every
// negative clk edge, plus hand-computed literal expectations along a directed sequence.
// No flow control on the DUT; stimulus changes 1 time unit after each rising edge.

module tb_flag_unit;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             reset;
    logic             we_flags;
    logic             carry_in;
    logic             zero_in;
    logic             negative_in;
    logic [2:0]       cond;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [2:0]       flags;
    logic             cond_true;
    logic [PTR_W:0]   count;
    logic             stack_full;
    logic             stack_empty;
    logic             err_ovf;
    logic             err_unf;

    int n_cmp;
    int n_bad;
    bit chk_en;

    // Reference model state
    logic [2:0] m_stk[$];
    logic [2:0] m_flags;
    logic       m_ovf;
    logic       m_unf;

    flag_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .we_flags    (we_flags),
        .carry_in    (carry_in),
        .zero_in     (zero_in),
        .negative_in (negative_in),
        .cond        (cond),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .flags       (flags),
        .cond_true   (cond_true),
        .count       (count),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Branch condition truth table on a {c,z,n} word.
    function automatic logic cond_of(input logic [2:0] c, input logic [2:0] f);
        logic cv, zv, nv;
        cv = f[2]; zv = f[1]; nv = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return zv;
            3'd2: return !zv;
            3'd3: return cv;
            3'd4: return !cv;
            3'd5: return nv;
            3'd6: return !nv;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: LIFO as a queue, rules applied directly.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_stk.delete();
            m_flags = 3'b000;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            logic ovf_now, unf_now;
            ovf_now = 1'b0;
            unf_now = 1'b0;
            if (push && pop) begin
                if (we_flags) m_flags = {carry_in, zero_in, negative_in};
            end else if (pop) begin
                if (m_stk.size() > 0) begin
                    m_flags = m_stk.pop_back();
                end else begin
                    unf_now = 1'b1;
                    if (we_flags) m_flags = {carry_in, zero_in, negative_in};
                end
            end else begin
                if (push) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(m_flags);
                    else ovf_now = 1'b1;
                end
                if (we_flags) m_flags = {carry_in, zero_in, negative_in};
            end
            m_ovf = ovf_now | (m_ovf & !clr_err);
            m_unf = unf_now | (m_unf & !clr_err);
        end
    end

    // Expected cond_true from model state and current inputs.
    function automatic logic exp_cond();
        logic [2:0] f;
        f = m_flags;
`ifdef FLAG_BYPASS_EN
        if (we_flags && !(pop && !push && m_stk.size() > 0))
            f = {carry_in, zero_in, negative_in};
`endif
        return cond_of(cond, f);
    endfunction

    // Compare process: every cycle once the bench is out of its initial reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_flags",     8'(flags),       8'(m_flags));
            check("m_count",     8'(count),       8'(m_stk.size()));
            check("m_full",      8'(stack_full),  8'(m_stk.size() == DEPTH));
            check("m_empty",     8'(stack_empty), 8'(m_stk.size() == 0));
            check("m_err_ovf",   8'(err_ovf),     8'(m_ovf));
            check("m_err_unf",   8'(err_unf),     8'(m_unf));
            check("m_cond_true", 8'(cond_true),   8'(exp_cond()));
        end
    end

    task automatic idle_inputs();
        we_flags = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    // One clock with the given controls, then return to idle 1 unit after the edge.
    task automatic cyc(input logic w, input logic [2:0] f, input logic pu,
                       input logic po, input logic cl);
        we_flags = w;
        {carry_in, zero_in, negative_in} = f;
        push = pu; pop = po; clr_err = cl;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic sweep_cond();
        for (int c = 0; c < 8; c++) begin
            cond = 3'(c);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        reset = 1'b0;
        cond = 3'b000;
        {carry_in, zero_in, negative_in} = 3'b000;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        cond = 3'b000; #1;
        check("rst_cond000", 8'(cond_true), 8'h1);
        cond = 3'b111; #1;
        check("rst_cond111", 8'(cond_true), 8'h0);
        check("rst_flags", 8'(flags), 8'h0);
        check("rst_count", 8'(count), 8'h0);
        check("rst_empty", 8'(stack_empty), 8'h1);
        check("rst_errs", 8'({err_ovf, err_unf}), 8'h0);

        // Flag write c=1 z=0 n=1
        cyc(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        check("wr_flags", 8'(flags), 8'h5);
        cond = 3'b011; #1; check("c_cond011", 8'(cond_true), 8'h1);
        cond = 3'b001; #1; check("c_cond001", 8'(cond_true), 8'h0);
        cond = 3'b110; #1; check("c_cond110", 8'(cond_true), 8'h0);
        sweep_cond();

        // Push saves pre-update flags while we_flags loads new ones
        cyc(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        check("pw_flags", 8'(flags), 8'h2);
        check("pw_count", 8'(count), 8'h1);
        cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        check("pop_flags", 8'(flags), 8'h4);
        check("pop_count", 8'(count), 8'h0);

        // Fill the stack, then overflow
        cyc(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= 5; k++) cyc(1'b1, 3'(k), 1'b1, 1'b0, 1'b0);
        check("fill_count", 8'(count), 8'h4);
        check("fill_full", 8'(stack_full), 8'h1);
        check("fill_ovf0", 8'(err_ovf), 8'h0);
        cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        check("ovf_count", 8'(count), 8'h4);
        check("ovf_err", 8'(err_ovf), 8'h1);
        sweep_cond();
        cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b0); check("pop1", 8'(flags), 8'h4);
        cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b0); check("pop2", 8'(flags), 8'h3);
        cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b0); check("pop3", 8'(flags), 8'h2);
        cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b0); check("pop4", 8'(flags), 8'h1);
        check("drain_empty", 8'(stack_empty), 8'h1);
        cyc(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 8'(err_ovf), 8'h0);

        // Underflow: flag write still applies
        cyc(1'b1, 3'b110, 1'b0, 1'b1, 1'b0);
        check("unf_flags", 8'(flags), 8'h6);
        check("unf_err", 8'(err_unf), 8'h1);
        cyc(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        check("clr_unf", 8'(err_unf), 8'h0);

        // Push and pop together with count=2
        cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3'b011, 1'b1, 1'b1, 1'b0);
        check("pp_count", 8'(count), 8'h2);
        check("pp_flags", 8'(flags), 8'h3);
        check("pp_errs", 8'({err_ovf, err_unf}), 8'h0);

        // New error in the clearing cycle wins
        cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
        check("clr_vs_ovf", 8'(err_ovf), 8'h1);

        // Reset mid-operation, during a pending pop
        pop = 1'b1; we_flags = 1'b1; {carry_in, zero_in, negative_in} = 3'b111;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_flags", 8'(flags), 8'h0);
        check("mid_rst_count", 8'(count), 8'h0);
        check("mid_rst_ovf", 8'(err_ovf), 8'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        {carry_in, zero_in, negative_in} = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Flag forwarding into cond_true
        we_flags = 1'b1; {carry_in, zero_in, negative_in} = 3'b010; cond = 3'b001;
        #1;
`ifdef FLAG_BYPASS_EN
        check("bypass_cond", 8'(cond_true), 8'h1);
`else
        check("nobypass_cond", 8'(cond_true), 8'h0);
`endif
        check("bypass_flags_reg", 8'(flags), 8'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        check("after_bypass_flags", 8'(flags), 8'h2);

        // Mixed traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            cond = 3'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 35),
                1'($urandom_range(0, 99) < 10));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
